// File: rtl/reorder_buffer.sv
// Dual-dispatch, triple-completion, dual-retire reorder buffer with a per-physical-register
// forwarding table that publishes completed results until the register is reallocated.
module reorder_buffer #(
    parameter int PC_SIZE              = 32,
    parameter int WORD_SIZE            = 32,
    parameter int NUM_P_REGS           = 64,
    parameter int ROB_SIZE             = 16,
    parameter int CONTR_SIG_SIZE       = 5,
    parameter int CONTR_REGWRITE_INDEX = 1,
    localparam int PR = $clog2(NUM_P_REGS),
    localparam int RI = $clog2(ROB_SIZE)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    input  logic                                  alloc0_i,
    input  logic                                  alloc1_i,
    input  logic [PR-1:0]                         alloc_dest0_i,
    input  logic [PR-1:0]                         alloc_dest1_i,
    input  logic [CONTR_SIG_SIZE-1:0]             alloc_contr0_i,
    input  logic [CONTR_SIG_SIZE-1:0]             alloc_contr1_i,
    input  logic [PC_SIZE-1:0]                    alloc_pc0_i,
    input  logic [PC_SIZE-1:0]                    alloc_pc1_i,
    output logic [RI-1:0]                         rob_index0_o,
    output logic [RI-1:0]                         rob_index1_o,
    output logic                                  rob_full_o,
    input  logic                                  en_complete_instr0_i,
    input  logic                                  en_complete_instr1_i,
    input  logic                                  en_complete_instr2_i,
    input  logic [RI-1:0]                         index_complete_instr0_i,
    input  logic [RI-1:0]                         index_complete_instr1_i,
    input  logic [RI-1:0]                         index_complete_instr2_i,
    input  logic [PC_SIZE-1:0]                    pc_complete_instr0_i,
    input  logic [PC_SIZE-1:0]                    pc_complete_instr1_i,
    input  logic [PC_SIZE-1:0]                    pc_complete_instr2_i,
    input  logic [WORD_SIZE-1:0]                  val_complete_instr0_i,
    input  logic [WORD_SIZE-1:0]                  val_complete_instr1_i,
    input  logic [WORD_SIZE-1:0]                  val_complete_instr2_i,
    output logic [NUM_P_REGS-1:0]                 rob_fwd_table_ready_o,
    output logic [NUM_P_REGS-1:0][WORD_SIZE-1:0]  rob_fwd_table_val_o,
    output logic                                  retire0_o,
    output logic                                  retire1_o,
    output logic [PR-1:0]                         retire_dest0_o,
    output logic [PR-1:0]                         retire_dest1_o,
    output logic                                  retire_regwrite0_o,
    output logic                                  retire_regwrite1_o,
    output logic [WORD_SIZE-1:0]                  retire_val0_o,
    output logic [WORD_SIZE-1:0]                  retire_val1_o
);
    localparam int CW = RI + 1;

    logic [ROB_SIZE-1:0]       valid_q, valid_d, complete_q, complete_d;
    logic [PR-1:0]             dest_q  [ROB_SIZE];
    logic [PR-1:0]             dest_d  [ROB_SIZE];
    logic [CONTR_SIG_SIZE-1:0] contr_q [ROB_SIZE];
    logic [CONTR_SIG_SIZE-1:0] contr_d [ROB_SIZE];
    logic [PC_SIZE-1:0]        pc_q    [ROB_SIZE];
    logic [PC_SIZE-1:0]        pc_d    [ROB_SIZE];
    logic [WORD_SIZE-1:0]      val_q   [ROB_SIZE];
    logic [WORD_SIZE-1:0]      val_d   [ROB_SIZE];

    logic [RI-1:0]             head_q, head_d, tail_q, tail_d, head1;
    logic [CW-1:0]             count_q, count_d;
    logic [NUM_P_REGS-1:0]     ready_q, ready_d;
    logic [NUM_P_REGS-1:0][WORD_SIZE-1:0] fwd_q, fwd_d;

    logic [2:0]                c_en;
    logic [2:0][RI-1:0]        c_idx;
    logic [2:0][PC_SIZE-1:0]   c_pc;
    logic [2:0][WORD_SIZE-1:0] c_val;
    logic                      grant0, grant1;
    logic                      unused_contr;

    assign c_en  = {en_complete_instr2_i, en_complete_instr1_i, en_complete_instr0_i};
    assign c_idx = {index_complete_instr2_i, index_complete_instr1_i, index_complete_instr0_i};
    assign c_pc  = {pc_complete_instr2_i, pc_complete_instr1_i, pc_complete_instr0_i};
    assign c_val = {val_complete_instr2_i, val_complete_instr1_i, val_complete_instr0_i};

    // Full leaves headroom for a dual dispatch, so a granted pair can never overrun head.
    assign rob_full_o   = (count_q > CW'(ROB_SIZE - 2));
    assign grant0       = alloc0_i & ~rob_full_o;
    assign grant1       = alloc1_i & ~rob_full_o;
    assign rob_index0_o = tail_q;
    assign rob_index1_o = tail_q + RI'(alloc0_i);

    assign head1              = head_q + RI'(1);
    assign retire0_o          = valid_q[head_q] & complete_q[head_q];
    assign retire1_o          = retire0_o & valid_q[head1] & complete_q[head1];
    assign retire_dest0_o     = dest_q[head_q];
    assign retire_dest1_o     = dest_q[head1];
    assign retire_regwrite0_o = contr_q[head_q][CONTR_REGWRITE_INDEX];
    assign retire_regwrite1_o = contr_q[head1][CONTR_REGWRITE_INDEX];
    assign retire_val0_o      = val_q[head_q];
    assign retire_val1_o      = val_q[head1];

    assign rob_fwd_table_ready_o = ready_q;
    assign rob_fwd_table_val_o   = fwd_q;

    // Only the regwrite bit is consumed internally; the rest of the bus is carried for debug.
    always_comb begin
        unused_contr = 1'b0;
        for (int e = 0; e < ROB_SIZE; e++) unused_contr = unused_contr ^ (^contr_q[e]);
    end

    always_comb begin
        valid_d    = valid_q;
        complete_d = complete_q;
        dest_d     = dest_q;
        contr_d    = contr_q;
        pc_d       = pc_q;
        val_d      = val_q;
        ready_d    = ready_q;
        fwd_d      = fwd_q;

        // Ascending order lets the highest-numbered port win duplicate indices.
        for (int k = 0; k < 3; k++) begin
            if (c_en[k] && valid_q[c_idx[k]] && (pc_q[c_idx[k]] == c_pc[k])) begin
                complete_d[c_idx[k]] = 1'b1;
                val_d[c_idx[k]]      = c_val[k];
                if (contr_q[c_idx[k]][CONTR_REGWRITE_INDEX] && (dest_q[c_idx[k]] != '0)) begin
                    ready_d[dest_q[c_idx[k]]] = 1'b1;
                    fwd_d[dest_q[c_idx[k]]]   = c_val[k];
                end
            end
        end

        if (retire0_o) begin
            valid_d[head_q]    = 1'b0;
            complete_d[head_q] = 1'b0;
        end
        if (retire1_o) begin
            valid_d[head1]    = 1'b0;
            complete_d[head1] = 1'b0;
        end

        // Allocation comes last so a fresh producer hides any same-edge result for its dest.
        if (grant0) begin
            valid_d[tail_q]        = 1'b1;
            complete_d[tail_q]     = 1'b0;
            dest_d[tail_q]         = alloc_dest0_i;
            contr_d[tail_q]        = alloc_contr0_i;
            pc_d[tail_q]           = alloc_pc0_i;
            ready_d[alloc_dest0_i] = 1'b0;
        end
        if (grant1) begin
            valid_d[rob_index1_o]    = 1'b1;
            complete_d[rob_index1_o] = 1'b0;
            dest_d[rob_index1_o]     = alloc_dest1_i;
            contr_d[rob_index1_o]    = alloc_contr1_i;
            pc_d[rob_index1_o]       = alloc_pc1_i;
            ready_d[alloc_dest1_i]   = 1'b0;
        end
        ready_d[0] = 1'b0;

        head_d  = head_q + RI'(retire0_o) + RI'(retire1_o);
        tail_d  = tail_q + RI'(grant0) + RI'(grant1);
        count_d = count_q + CW'(grant0) + CW'(grant1) - CW'(retire0_o) - CW'(retire1_o);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q    <= '0;
            complete_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ready_q    <= '0;
            fwd_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            complete_q <= complete_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            fwd_q      <= fwd_d;
        end
    end

    // Payload is qualified by valid, so it needs no reset.
    always_ff @(posedge clk_i) begin
        dest_q  <= dest_d;
        contr_q <= contr_d;
        pc_q    <= pc_d;
        val_q   <= val_d;
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus random traffic, all checked
// against an in-order queue model of the buffer and a per-register forwarding table model.
module tb_reorder_buffer;
    localparam int PR = 6, RI = 4, RS = 16, NP = 64, W = 32, PCW = 32, CS = 5, RWI = 1;

    logic clk_i = 1'b0;
    logic rst_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic alloc0_i, alloc1_i;
    logic [PR-1:0] alloc_dest0_i, alloc_dest1_i;
    logic [CS-1:0] alloc_contr0_i, alloc_contr1_i;
    logic [PCW-1:0] alloc_pc0_i, alloc_pc1_i;
    logic [RI-1:0] rob_index0_o, rob_index1_o;
    logic rob_full_o;
    logic en_complete_instr0_i, en_complete_instr1_i, en_complete_instr2_i;
    logic [RI-1:0] index_complete_instr0_i, index_complete_instr1_i, index_complete_instr2_i;
    logic [PCW-1:0] pc_complete_instr0_i, pc_complete_instr1_i, pc_complete_instr2_i;
    logic [W-1:0] val_complete_instr0_i, val_complete_instr1_i, val_complete_instr2_i;
    logic [NP-1:0] rob_fwd_table_ready_o;
    logic [NP-1:0][W-1:0] rob_fwd_table_val_o;
    logic retire0_o, retire1_o;
    logic [PR-1:0] retire_dest0_o, retire_dest1_o;
    logic retire_regwrite0_o, retire_regwrite1_o;
    logic [W-1:0] retire_val0_o, retire_val1_o;

    reorder_buffer dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .alloc0_i(alloc0_i), .alloc1_i(alloc1_i),
        .alloc_dest0_i(alloc_dest0_i), .alloc_dest1_i(alloc_dest1_i),
        .alloc_contr0_i(alloc_contr0_i), .alloc_contr1_i(alloc_contr1_i),
        .alloc_pc0_i(alloc_pc0_i), .alloc_pc1_i(alloc_pc1_i),
        .rob_index0_o(rob_index0_o), .rob_index1_o(rob_index1_o), .rob_full_o(rob_full_o),
        .en_complete_instr0_i(en_complete_instr0_i), .en_complete_instr1_i(en_complete_instr1_i),
        .en_complete_instr2_i(en_complete_instr2_i),
        .index_complete_instr0_i(index_complete_instr0_i), .index_complete_instr1_i(index_complete_instr1_i),
        .index_complete_instr2_i(index_complete_instr2_i),
        .pc_complete_instr0_i(pc_complete_instr0_i), .pc_complete_instr1_i(pc_complete_instr1_i),
        .pc_complete_instr2_i(pc_complete_instr2_i),
        .val_complete_instr0_i(val_complete_instr0_i), .val_complete_instr1_i(val_complete_instr1_i),
        .val_complete_instr2_i(val_complete_instr2_i),
        .rob_fwd_table_ready_o(rob_fwd_table_ready_o), .rob_fwd_table_val_o(rob_fwd_table_val_o),
        .retire0_o(retire0_o), .retire1_o(retire1_o),
        .retire_dest0_o(retire_dest0_o), .retire_dest1_o(retire_dest1_o),
        .retire_regwrite0_o(retire_regwrite0_o), .retire_regwrite1_o(retire_regwrite1_o),
        .retire_val0_o(retire_val0_o), .retire_val1_o(retire_val1_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: live entries in allocation order; an entry's slot is fixed at allocation.
    typedef struct {
        int           idx;
        logic [5:0]   dest;
        logic [4:0]   contr;
        logic [31:0]  pc;
        logic [31:0]  val;
        bit           cmp;
    } ent_t;

    ent_t        q[$];
    int          m_head;
    logic [63:0] m_rdy;
    logic [31:0] m_fwd [NP];

    bit          a0, a1;
    logic [5:0]  d0, d1;
    logic [4:0]  c0, c1;
    logic [31:0] p0, p1;
    bit          ce [3];
    logic [3:0]  ci [3];
    logic [31:0] cp [3];
    logic [31:0] cv [3];
    logic [31:0] pc_ctr = 32'h1000;

    task automatic model_reset();
        q.delete();
        m_head = 0;
        m_rdy  = '0;
        for (int r = 0; r < NP; r++) m_fwd[r] = '0;
    endtask

    task automatic clr_in();
        a0 = 0; a1 = 0;
        d0 = '0; d1 = '0; c0 = '0; c1 = '0; p0 = '0; p1 = '0;
        for (int k = 0; k < 3; k++) begin
            ce[k] = 0; ci[k] = '0; cp[k] = '0; cv[k] = '0;
        end
    endtask

    task automatic drive_pins();
        alloc0_i = a0; alloc1_i = a1;
        alloc_dest0_i = d0; alloc_dest1_i = d1;
        alloc_contr0_i = c0; alloc_contr1_i = c1;
        alloc_pc0_i = p0; alloc_pc1_i = p1;
        en_complete_instr0_i = ce[0]; en_complete_instr1_i = ce[1]; en_complete_instr2_i = ce[2];
        index_complete_instr0_i = ci[0]; index_complete_instr1_i = ci[1]; index_complete_instr2_i = ci[2];
        pc_complete_instr0_i = cp[0]; pc_complete_instr1_i = cp[1]; pc_complete_instr2_i = cp[2];
        val_complete_instr0_i = cv[0]; val_complete_instr1_i = cv[1]; val_complete_instr2_i = cv[2];
    endtask

    // Called at a negedge: drive, check against the model, advance the model, cross one posedge.
    task automatic step();
        int   tail;
        bit   full, r0, r1;
        ent_t e;
        drive_pins();
        #1;
        tail = (m_head + q.size()) % RS;
        full = (q.size() > RS - 2);
        r0   = (q.size() > 0) && q[0].cmp;
        r1   = r0 && (q.size() > 1) && q[1].cmp;
        chk("rob_index0", rob_index0_o, tail);
        chk("rob_index1", rob_index1_o, (tail + int'(a0)) % RS);
        chk("rob_full", rob_full_o, full);
        chk("retire0", retire0_o, r0);
        chk("retire1", retire1_o, r1);
        if (r0) begin
            chk("retire_dest0", retire_dest0_o, q[0].dest);
            chk("retire_regwrite0", retire_regwrite0_o, q[0].contr[RWI]);
            chk("retire_val0", retire_val0_o, q[0].val);
        end
        if (r1) begin
            chk("retire_dest1", retire_dest1_o, q[1].dest);
            chk("retire_regwrite1", retire_regwrite1_o, q[1].contr[RWI]);
            chk("retire_val1", retire_val1_o, q[1].val);
        end
        chk("fwd_ready", rob_fwd_table_ready_o, m_rdy);
        for (int r = 0; r < NP; r++) chk($sformatf("fwd_val[%0d]", r), rob_fwd_table_val_o[r], m_fwd[r]);

        for (int k = 0; k < 3; k++) begin
            if (ce[k]) begin
                for (int j = 0; j < q.size(); j++) begin
                    if (q[j].idx == int'(ci[k]) && q[j].pc == cp[k]) begin
                        e = q[j];
                        e.cmp = 1;
                        e.val = cv[k];
                        q[j] = e;
                        if (e.contr[RWI] && e.dest != 0) begin
                            m_rdy[e.dest] = 1'b1;
                            m_fwd[e.dest] = cv[k];
                        end
                    end
                end
            end
        end
        if (r0) begin void'(q.pop_front()); m_head = (m_head + 1) % RS; end
        if (r1) begin void'(q.pop_front()); m_head = (m_head + 1) % RS; end
        if (!full) begin
            if (a0) begin
                e = '{idx: tail, dest: d0, contr: c0, pc: p0, val: 32'h0, cmp: 1'b0};
                q.push_back(e);
                m_rdy[d0] = 1'b0;
            end
            if (a1) begin
                e = '{idx: (tail + int'(a0)) % RS, dest: d1, contr: c1, pc: p1, val: 32'h0, cmp: 1'b0};
                q.push_back(e);
                m_rdy[d1] = 1'b0;
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic sync_reset();
        rst_n_i = 1'b0;
        clr_in();
        drive_pins();
        model_reset();
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    task automatic async_reset_mid_cycle();
        #3;
        rst_n_i = 1'b0;
        #1;
        chk("rst_retire0", retire0_o, 0);
        chk("rst_retire1", retire1_o, 0);
        chk("rst_full", rob_full_o, 0);
        chk("rst_index0", rob_index0_o, 0);
        chk("rst_ready", rob_fwd_table_ready_o, 0);
        model_reset();
        clr_in();
        drive_pins();
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    task automatic alloc_one(input int slot, input logic [5:0] dest);
        pc_ctr = pc_ctr + 4;
        if (slot == 0) begin a0 = 1; d0 = dest; c0 = 5'b00010; p0 = pc_ctr; end
        else           begin a1 = 1; d1 = dest; c1 = 5'b00010; p1 = pc_ctr; end
    endtask

    task automatic complete_first_pending(input int k, input logic [31:0] v);
        for (int j = 0; j < q.size(); j++) begin
            if (!q[j].cmp) begin
                ce[k] = 1; ci[k] = 4'(q[j].idx); cp[k] = q[j].pc; cv[k] = v;
                break;
            end
        end
    endtask

    initial begin
        clr_in();
        drive_pins();
        model_reset();
        #3;
        chk("init_retire0", retire0_o, 0);
        chk("init_retire1", retire1_o, 0);
        chk("init_full", rob_full_o, 0);
        chk("init_index0", rob_index0_o, 0);
        chk("init_ready", rob_fwd_table_ready_o, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Dual alloc, out-of-order completion, then simultaneous completion and dual retire.
        a0 = 1; a1 = 1; d0 = 6'd5; d1 = 6'd6; c0 = 5'b00010; c1 = 5'b00010;
        p0 = 32'h100; p1 = 32'h104;
        step();
        clr_in(); step();
        ce[0] = 1; ci[0] = 4'd1; cp[0] = 32'h104; cv[0] = 32'hAA;
        step();
        clr_in(); step();
        chk("req21_ready6", rob_fwd_table_ready_o[6], 1);
        chk("req21_val6", rob_fwd_table_val_o[6], 32'hAA);
        chk("req21_no_retire", retire0_o, 0);
        ce[0] = 1; ci[0] = 4'd0; cp[0] = 32'h100; cv[0] = 32'h11;
        ce[1] = 1; ci[1] = 4'd1; cp[1] = 32'h104; cv[1] = 32'h22;
        step();
        chk("req22_retire0", retire0_o, 1);
        chk("req22_retire1", retire1_o, 1);
        chk("req22_val0", retire_val0_o, 32'h11);
        chk("req22_val1", retire_val1_o, 32'h22);
        clr_in(); step();
        chk("req22_head", rob_index0_o, 2);

        // Fill to the full threshold, attempt overflow, retire one.
        for (int i = 0; i < 7; i++) begin
            clr_in();
            alloc_one(0, 6'($urandom_range(1, 63)));
            alloc_one(1, 6'($urandom_range(1, 63)));
            step();
        end
        clr_in(); alloc_one(0, 6'd20); step();
        chk("req23_full", rob_full_o, 1);
        for (int i = 0; i < 2; i++) begin
            clr_in(); alloc_one(0, 6'd21); alloc_one(1, 6'd22); step();
        end
        clr_in(); ce[2] = 1; ci[2] = 4'(q[0].idx); cp[2] = q[0].pc; cv[2] = 32'h55; step();
        clr_in(); step();
        chk("req23_not_full", rob_full_o, 0);

        // Rejected completions: wrong pc, and an index with no live entry.
        clr_in(); ce[0] = 1; ci[0] = 4'(q[1].idx); cp[0] = q[1].pc + 32'd4; cv[0] = 32'hDEAD; step();
        clr_in(); ce[1] = 1; ci[1] = 4'((m_head + q.size()) % RS); cp[1] = 32'h0; cv[1] = 32'hBEEF; step();
        clr_in(); step();

        // Alloc of dest 9 beats a same-edge completion that targets dest 9.
        sync_reset();
        a0 = 1; d0 = 6'd9; c0 = 5'b00010; p0 = 32'h900; step();
        clr_in(); a0 = 1; d0 = 6'd9; c0 = 5'b00010; p0 = 32'h904;
        ce[0] = 1; ci[0] = 4'd0; cp[0] = 32'h900; cv[0] = 32'h99;
        step();
        chk("req25_ready9", rob_fwd_table_ready_o[9], 0);

        // Long single-issue stream crossing the pointer wrap.
        for (int i = 0; i < 40; i++) begin
            clr_in();
            alloc_one(0, 6'($urandom_range(0, 63)));
            complete_first_pending(0, $urandom);
            step();
        end
        clr_in(); step(); step();

        // Asynchronous reset with eight live entries.
        sync_reset();
        for (int i = 0; i < 4; i++) begin
            clr_in(); alloc_one(0, 6'(2 * i + 1)); alloc_one(1, 6'(2 * i + 2)); step();
        end
        clr_in(); complete_first_pending(0, 32'h77); complete_first_pending(1, 32'h78); step();
        chk("req26_live", (m_head + q.size()) % RS, rob_index0_o);
        async_reset_mid_cycle();
        clr_in(); alloc_one(0, 6'd3); step();

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            clr_in();
            if ($urandom_range(0, 9) < 6) alloc_one(0, 6'($urandom_range(0, 15)));
            if ($urandom_range(0, 9) < 5) alloc_one(1, 6'($urandom_range(0, 15)));
            c0 = 5'($urandom); c1 = 5'($urandom);
            for (int k = 0; k < 3; k++) begin
                if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
                    int j;
                    j = $urandom_range(0, q.size() - 1);
                    ce[k] = 1; ci[k] = 4'(q[j].idx); cv[k] = $urandom;
                    cp[k] = ($urandom_range(0, 7) == 0) ? q[j].pc + 32'd4 : q[j].pc;
                end else if ($urandom_range(0, 7) == 0) begin
                    ce[k] = 1; ci[k] = 4'($urandom_range(0, RS - 1)); cp[k] = $urandom; cv[k] = $urandom;
                end
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  - PC_SIZE, 32, PC width
  - WORD_SIZE, 32, data width
  - NUM_P_REGS, 64, physical registers
  - ROB_SIZE, 16, entries, power of two
  - CONTR_SIG_SIZE, 5, control bus width
  - CONTR_REGWRITE_INDEX, 1, regwrite bit in control bus
REQ-002 Ports SHALL be (name, direction, width, meaning); PR = $clog2(NUM_P_REGS), RI = $clog2(ROB_SIZE):
  - clk_i  in  1  the single clock
  - rst_n_i  in  1  reset, asynchronous, active-low
  - alloc0_i, alloc1_i  in  1  dispatch allocation requests
  - alloc_dest0_i, alloc_dest1_i  in  PR  destination physical registers
  - alloc_contr0_i, alloc_contr1_i  in  CONTR_SIG_SIZE  control bus
  - alloc_pc0_i, alloc_pc1_i  in  PC_SIZE  PCs
  - rob_index0_o, rob_index1_o  out  RI  indices granted to slots 0 and 1
  - rob_full_o  out  1  fewer than 2 free entries
  - en_complete_instr{0,1,2}_i  in  1  completion strobes from issue
  - index_complete_instr{0,1,2}_i  in  RI  completing entry index
  - pc_complete_instr{0,1,2}_i  in  PC_SIZE  completing PC
  - val_complete_instr{0,1,2}_i  in  WORD_SIZE  result value
  - rob_fwd_table_ready_o  out  1 x NUM_P_REGS  per-register value-valid flag
  - rob_fwd_table_val_o  out  WORD_SIZE x NUM_P_REGS  per-register value
  - retire0_o, retire1_o  out  1  in-order retire strobes
  - retire_dest0_o, retire_dest1_o  out  PR  retiring destinations
  - retire_regwrite0_o, retire_regwrite1_o  out  1  retiring regwrite bits
  - retire_val0_o, retire_val1_o  out  WORD_SIZE  retiring values

Function
REQ-003 Each entry SHALL hold: valid, complete, dest, contr, pc, val. Head, tail (RI bits, modulo ROB_SIZE) and count (0..ROB_SIZE) SHALL be registers.
REQ-004 rob_index0_o SHALL equal tail; rob_index1_o SHALL equal tail+alloc0_i (mod ROB_SIZE); both combinational.
REQ-005 rob_full_o SHALL be (count > ROB_SIZE-2), computed from registered count only.
REQ-006 At posedge, each granted alloc SHALL write its entry with valid=1, complete=0, dest/contr/pc from inputs. Tail SHALL advance by alloc0_i+alloc1_i.
REQ-007 Alloc requests SHALL be ignored entirely while rob_full_o=1: no entry written, no tail change.
REQ-008 At posedge, each enabled completion k SHALL set entry[index].complete=1 and entry[index].val=val_k. This SHALL occur only if entry[index].valid=1 and entry[index].pc equals pc_k; otherwise the completion is ignored.
REQ-009 An accepted completion with contr[CONTR_REGWRITE_INDEX]=1 and dest!=0 SHALL set ready[dest]=1 and fwd val[dest]=val_k at the same edge (visible the following cycle).
REQ-010 A granted alloc SHALL clear ready[alloc_dest] at that edge. Alloc clear SHALL override a same-edge completion set for the same register.
REQ-011 Retirement SHALL leave ready flags unchanged. ready[0] SHALL be constant 0.
REQ-012 retire0_o = entry[head].valid & complete; retire1_o = retire0_o & entry[head+1].valid & complete. Both combinational from registered state. retire_* data SHALL come from entries head and head+1.
REQ-013 At posedge, retired entries SHALL be invalidated, and head SHALL advance by retire0_o+retire1_o.
REQ-014 count SHALL update as count + allocs granted - retires; simultaneous alloc and retire are legal.
REQ-015 A completion arriving at edge N SHALL make its entry retire-eligible no earlier than cycle N+1 (1-cycle complete-to-retire latency).
REQ-016 Simultaneous completions to distinct indices SHALL all be accepted. Duplicate indices in one cycle: the highest k SHALL win.
REQ-017 Pointer wrap from ROB_SIZE-1 to 0 SHALL be seamless, including slot 1 and head+1 crossing the wrap.

Reset
REQ-018 While rst_n_i=0, state SHALL clear asynchronously: all valid/complete=0, head=tail=count=0, all ready=0, all fwd val=0.
REQ-019 In reset, retire0_o/retire1_o SHALL be 0, rob_full_o SHALL be 0, and rob_index0_o SHALL be 0.
REQ-020 Reset asserted mid-operation SHALL discard all in-flight entries; the first post-reset alloc SHALL receive index 0.

Verification
REQ-021 Dual alloc (dest 5, 6) at cycle 0 -> indices 0,1; complete index 1 val 0xAA at cycle 2 -> ready[6]=1, val 0xAA; retire0_o stays 0 until index 0 completes.
REQ-022 Complete index 0 and 1 at the same edge (vals 0x11, 0x22) -> next cycle retire0_o=retire1_o=1, retire_val 0x11/0x22; head=2 after the edge.
REQ-023 Allocate 15 entries -> rob_full_o=1; further allocs are ignored, tail unchanged; one retire -> rob_full_o=0.
REQ-024 Run 40 single allocs/completes/retires -> indices wrap 15->0 and retire order matches allocation order.
REQ-025 Completion with a mismatched pc, or to an invalid index -> no state change. Alloc and complete of the same dest 9 at one edge -> ready[9]=0.
REQ-026 Assert rst_n_i low asynchronously mid-stream with 8 entries live -> outputs clear immediately; next alloc gets index 0.
